// File: rtl/keypad_scan_entry_if.sv
// Keypad-side and display-side signals of the keypad scanner.
// The environment drives the columns and the clear; the scanner drives rows and entry data.
interface keypad_scan_entry_if #(
  parameter int WIDTH_DATA = 16
);
  logic [3:0]            i_col;
  logic                  i_clr;
  logic [3:0]            o_row;
  logic [WIDTH_DATA-1:0] o_data;
  logic                  o_key_valid;
  logic [3:0]            o_key_code;

  modport master (
    output i_col, i_clr,
    input  o_row, o_data, o_key_valid, o_key_code
  );

  modport slave (
    input  i_col, i_clr,
    output o_row, o_data, o_key_valid, o_key_code
  );
endinterface

// File: rtl/keypad_scan_entry.sv
// 4x4 matrix keypad scanner with whole-scan debounce.
// Accepted keys are shifted as hex digits into the display entry register.
module keypad_scan_entry #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int WIDTH_DATA     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  keypad_scan_entry_if.slave bus
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  function automatic logic [4:0] pop16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [3:0] low_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // snapshot bit index is 4*row+col
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      4'd15:   code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  logic [3:0]            col_meta_r;
  logic [3:0]            col_sync_r;
  logic [DIV_W-1:0]      div_r;
  logic [1:0]            row_idx_r;
  logic [3:0]            row_r;
  logic [15:0]           snap_r;
  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [3:0]            cand_r;
  logic                  key_valid_r;
  logic [3:0]            key_code_r;
  logic [WIDTH_DATA-1:0] data_r;

  logic                  tick_s;
  logic                  scan_done_s;
  logic [15:0]           snap_next_s;
  logic [4:0]            hits_s;
  logic                  none_s;
  logic                  single_s;
  logic [3:0]            key_s;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic [WIDTH_DATA-1:0] shift_s;

  // two-flop synchroniser for the asynchronous column inputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_meta_r <= 4'b1111;
      col_sync_r <= 4'b1111;
    end else begin
      col_meta_r <= bus.i_col;
      col_sync_r <= col_meta_r;
    end
  end

  // scan classification, including the row being captured on this tick
  always_comb begin
    snap_next_s = snap_r;
    snap_next_s[{row_idx_r, 2'b00} +: 4] = ~col_sync_r;
    tick_s      = (div_r == DIV_LAST);
    scan_done_s = tick_s && (row_idx_r == 2'd3);
    hits_s      = pop16(snap_next_s);
    none_s      = (hits_s == 5'd0);
    single_s    = (hits_s == 5'd1);
    key_s       = key_map(low_idx(snap_next_s));
    cnt_inc_s   = cnt_r + CNT_ONE;
    shift_s     = {data_r[WIDTH_DATA-5:0], key_s};
  end

  // row step divider, row drive and snapshot capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_r     <= '0;
      row_idx_r <= 2'd0;
      row_r     <= 4'b1110;
      snap_r    <= 16'h0000;
    end else if (tick_s) begin
      div_r     <= '0;
      row_idx_r <= row_idx_r + 2'd1;
      row_r     <= ~(4'b0001 << (row_idx_r + 2'd1));
      snap_r    <= snap_next_s;
    end else begin
      div_r     <= div_r + DIV_W'(1);
    end
  end

  // debounce FSM with registered accept outputs and entry register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      cand_r      <= 4'h0;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
      data_r      <= '0;
    end else begin
      key_valid_r <= 1'b0;
      if (scan_done_s) begin
        case (state_r)
          ST_IDLE: begin
            if (single_s) begin
              cand_r <= key_s;
              cnt_r  <= CNT_ONE;
              if (DEBOUNCE_SCANS == 1) begin
                key_valid_r <= 1'b1;
                key_code_r  <= key_s;
                data_r      <= shift_s;
                state_r     <= ST_PRESSED;
              end else begin
                state_r <= ST_DEBOUNCE;
              end
            end else begin
              cnt_r <= '0;
            end
          end
          ST_DEBOUNCE: begin
            if (single_s && (key_s == cand_r)) begin
              cnt_r <= cnt_inc_s;
              if (cnt_inc_s == CNT_DONE) begin
                key_valid_r <= 1'b1;
                key_code_r  <= key_s;
                data_r      <= shift_s;
                state_r     <= ST_PRESSED;
              end else begin
                state_r <= ST_DEBOUNCE;
              end
            end else if (single_s) begin
              cand_r <= key_s;
              cnt_r  <= CNT_ONE;
            end else begin
              cnt_r   <= '0;
              state_r <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            if (none_s) begin
              cnt_r <= CNT_ONE;
              if (DEBOUNCE_SCANS == 1) begin
                state_r <= ST_IDLE;
              end else begin
                state_r <= ST_RELEASE;
              end
            end else begin
              state_r <= ST_PRESSED;
            end
          end
          ST_RELEASE: begin
            if (none_s) begin
              if (cnt_inc_s == CNT_DONE) begin
                cnt_r   <= '0;
                state_r <= ST_IDLE;
              end else begin
                cnt_r <= cnt_inc_s;
              end
            end else begin
              state_r <= ST_PRESSED;
            end
          end
          default: begin
            cnt_r   <= '0;
            state_r <= ST_IDLE;
          end
        endcase
      end
      // clear overrides a simultaneous shift; valid and code still update
      if (bus.i_clr) begin
        data_r <= '0;
      end
    end
  end

  assign bus.o_row       = row_r;
  assign bus.o_data      = data_r;
  assign bus.o_key_valid = key_valid_r;
  assign bus.o_key_code  = key_code_r;
endmodule

// File: tb/tb_keypad_scan_entry.sv
// Scoreboard bench for keypad_scan_entry: a keypad model drives the columns,
// expected accepts are queued with the stimulus and checked by a pulse monitor.
`timescale 1ns/1ps
module tb_keypad_scan_entry;
  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int WIDTH_DATA     = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  keypad_scan_entry_if #(.WIDTH_DATA(WIDTH_DATA)) bus ();

  keypad_scan_entry #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .WIDTH_DATA    (WIDTH_DATA)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] data;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [15:0] keys    = 16'h0000;
  logic        rand_en = 1'b0;
  logic [3:0]  rand_col = 4'hF;
  logic        clr     = 1'b0;
  logic [3:0]  col_s;

  // keypad matrix: a held key pulls its column low while its row is driven low
  always_comb begin
    col_s = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r+c] && !bus.o_row[r]) col_s[c] = 1'b0;
      end
    end
    if (rand_en) col_s = rand_col;
  end
  assign bus.i_col = col_s;
  assign bus.i_clr = clr;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every cycle with o_key_valid high must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.o_key_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: code %0h data %0h at cycle %0d, none expected",
                 bus.o_key_code, bus.o_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("key_code", {28'd0, bus.o_key_code}, {28'd0, e.code});
        chk("key_data", {16'd0, bus.o_data}, {16'd0, e.data});
        if (e.at >= 0) chk("key_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic align();
    wait_until((cyc / 16 + 1) * 16);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_key(input logic [3:0] code, input logic [15:0] data, input int at);
    exp_t e;
    e.code = code;
    e.data = data;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int w;
    w = 0;
    while (sb.size() != 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected pulses missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic tap(input int idx, input logic [3:0] code, input logic [15:0] data);
    align();
    expect_key(code, data, -1);
    keys = 16'h0001 << idx;
    idle(64);
    keys = 16'h0000;
    idle(64);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_row"},   {28'd0, bus.o_row}, 32'h0000000E);
    chk({tag, "_data"},  {16'd0, bus.o_data}, 32'h00000000);
    chk({tag, "_valid"}, {31'd0, bus.o_key_valid}, 32'h00000000);
    chk({tag, "_code"},  {28'd0, bus.o_key_code}, 32'h00000000);
  endtask

  initial begin
    int t;
    // reset with garbage on the columns
    rand_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_col = 4'($urandom_range(0, 15));
      @(negedge clk);
      chk_reset_outputs("reset");
    end
    rand_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // row walk: one row low per SCAN_DIV cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("row_walk", {28'd0, bus.o_row}, {28'd0, ~(4'b0001 << ((cyc / 4) % 4))});
    end

    // single key r1c2 pressed after edge 20: first captured in scan 1, accepted at edge 48
    wait_until(20);
    expect_key(4'h6, 16'h0006, 48);
    keys = 16'h0040;
    idle(96);
    keys = 16'h0000;
    idle(64);
    drain("single_key", 16);

    // entry sequence 1 2 3 A 5
    tap(0, 4'h1, 16'h0061);
    tap(1, 4'h2, 16'h0612);
    tap(2, 4'h3, 16'h6123);
    tap(3, 4'hA, 16'h123A);
    tap(5, 4'h5, 16'h23A5);
    drain("entry_seq", 16);
    chk("entry_final", {16'd0, bus.o_data}, 32'h000023A5);

    // press bounce on r3c1: row-3 samples see P,N,N then steady P,P -> accept at T+80
    align();
    t = cyc;
    expect_key(4'h0, 16'h3A50, t + 80);
    for (int k = 0; k < 10; k++) begin
      keys = (k % 2 == 0) ? 16'h2000 : 16'h0000;
      idle(5);
    end
    keys = 16'h2000;
    wait_until(t + 128);
    // release bounce lasting one scan, then a clean release
    align();
    keys = 16'h0000;
    idle(16);
    keys = 16'h2000;
    idle(48);
    keys = 16'h0000;
    idle(64);
    drain("bounce", 16);

    // ghosting: r0c0 + r2c3 together never accept; dropping r2c3 accepts 1
    align();
    keys = 16'h0801;
    idle(64);
    expect_key(4'h1, 16'hA501, -1);
    keys = 16'h0001;
    idle(64);
    keys = 16'h0000;
    idle(64);
    drain("ghost", 16);

    // clear alone, then build 1234
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clear", {16'd0, bus.o_data}, 32'h00000000);
    tap(0, 4'h1, 16'h0001);
    tap(1, 4'h2, 16'h0012);
    tap(2, 4'h3, 16'h0123);
    tap(4, 4'h4, 16'h1234);
    drain("build_1234", 16);
    chk("pre_collision", {16'd0, bus.o_data}, 32'h00001234);

    // clear lands on the accept edge of key 7 (r2c0): data 0, pulse with code 7
    align();
    t = cyc;
    expect_key(4'h7, 16'h0000, t + 32);
    keys = 16'h0100;
    wait_until(t + 31);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    drain("clr_collision", 16);
    chk("collision_code", {28'd0, bus.o_key_code}, 32'h00000007);

    // reset while PRESSED; held key re-accepted two scans after release
    idle(20);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    idle(2);
    expect_key(4'h7, 16'h0007, 32);
    rst_n = 1'b1;
    idle(48);
    keys = 16'h0000;
    idle(64);
    drain("reaccept", 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/keypad_scan_entry.md
Name: keypad_scan_entry

Overview:
Scans a 4x4 matrix keypad by driving rows low one at a time and reading the columns back. Each key is debounced over whole scans. Every accepted key press is decoded to a 4-bit hex code and shifted into a 16-bit entry register. That register is the data source for the 4-digit seven-segment multiplexed display: it feeds the display's data_in, and the newest digit appears on data_in[3:0].

Parameters:
SCAN_DIV, 50000, i_clk cycles per row step; must be >= 2.
DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or a release; must be >= 1.
WIDTH_DATA, 16, entry register width; must be a multiple of 4.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  reset, asynchronous, active-low
i_col  input  4  keypad columns, active-low (pulled up), asynchronous to i_clk
i_clr  input  1  synchronous clear of o_data, active-high
o_row  output  4  row drive, active-low, exactly one row low at a time
o_data  output  WIDTH_DATA  entry register, newest digit in [3:0]
o_key_valid  output  1  one-cycle pulse when a press is accepted
o_key_code  output  4  code of the last accepted key

Behaviour:
- Reset values (async, i_rst_n=0): o_row=4'b1110, row index=0, divider=0, synchronisers=4'b1111, snapshot=0, FSM=IDLE, debounce count=0, o_data=0, o_key_valid=0, o_key_code=0.
- i_col passes through a 2-flop synchroniser (reset value 1s) before any use.
- Divider counts 0..SCAN_DIV-1 and wraps. tick=1 on the cycle the divider equals SCAN_DIV-1.
- On each tick:
  - the synchronised columns for the current row r are stored into snapshot bits [4r+3:4r], with 1=pressed;
  - r then advances 0→1→2→3→0, and o_row=~(1<<r).
  - A tick with r==3 completes a scan; the FSM evaluates the full 16-bit snapshot on that cycle.
- Scan result classes: NONE (no bits set); SINGLE(K) (exactly one bit set); MULTI (two or more bits set). MULTI is treated as NONE while in IDLE or DEBOUNCE, and as "key present" while in PRESSED or RELEASE.
- Key map (row r, column c → code):
  - r0: c0=1, c1=2, c2=3, c3=A
  - r1: c0=4, c1=5, c2=6, c3=B
  - r2: c0=7, c1=8, c2=9, c3=C
  - r3: c0=E (*), c1=0, c2=F (#), c3=D
- FSM, advancing only on scan-complete cycles:
  - IDLE:
    - on SINGLE(K): latch candidate K and set cnt=1;
    - if DEBOUNCE_SCANS==1, accept immediately and go to PRESSED;
    - otherwise go to DEBOUNCE.
  - DEBOUNCE:
    - SINGLE(same K): cnt+1; when cnt reaches DEBOUNCE_SCANS, accept and go to PRESSED;
    - SINGLE(different K'): restart with candidate K' and cnt=1;
    - NONE or MULTI: go to IDLE with cnt=0.
  - PRESSED:
    - NONE: cnt=1 and go to RELEASE (go straight to IDLE if DEBOUNCE_SCANS==1);
    - any key present: stay in PRESSED.
  - RELEASE:
    - NONE: cnt+1; when cnt reaches DEBOUNCE_SCANS, go to IDLE;
    - any key present: go back to PRESSED with no new accept.
- Accept action, registered and visible on the cycle after the scan-complete cycle:
  - o_key_valid=1 for exactly one cycle;
  - o_key_code=K;
  - o_data={o_data[WIDTH_DATA-5:0],K}, so the oldest digit falls out of the top.
- Auto-repeat is not supported: exactly one accept per debounced press.
- i_clr: o_data becomes 0 on the next edge. If i_clr coincides with an accept, the clear wins for o_data (result 0), while o_key_valid and o_key_code still update. i_clr has no effect on the scan or the FSM.
- Reset asserted mid-press: all state returns to reset values. A key still held after reset deasserts is treated as a new press and is accepted after debounce.
- Press-to-accept latency: DEBOUNCE_SCANS scans after the first scan that captures the key, plus 1 cycle. One scan is 4*SCAN_DIV cycles.

Test Plan:
Settings for all scenarios: SCAN_DIV=4, DEBOUNCE_SCANS=2, so one scan = 16 cycles.
- Reset: hold i_rst_n=0 with random i_col → o_row=1110, o_data=0000, o_key_valid=0, o_key_code=0. After release, o_row steps 1110→1101→1011→0111 every 4 cycles and wraps.
- Single key: model key r1c2 (pulls i_col[2] low while o_row[1]=0), held for 6 scans → exactly one o_key_valid pulse, o_key_code=6, o_data=0006, pulse occurring 2 full scans + 1 cycle after the first capturing scan.
- Entry sequence: press then release 1, 2, 3, A, 5, each held 4 scans with 4 scans released between → five pulses; o_data ends at 23A5.
- Bounce: key r3c1 toggled every 5 cycles for 3 scans, then held steady → no pulse during bouncing, one pulse after settling with code 0. Release bounce of 1 scan → no second pulse.
- Ghosting: r0c0 and r2c3 held together → no pulse. Drop r2c3 → one pulse with code 1.
- Clear collision: assert i_clr on the same cycle an accept registers, with o_data=1234 → o_data=0000, o_key_valid=1 with the new code. Separately, assert i_rst_n=0 during PRESSED → all outputs return to reset values; the still-held key is re-accepted after 2 scans.
